sprite_ram_arbiter: RTL and testbench

SPRITE_RAM_ARBITER -- requirements
Module: sprite_ram_arbiter

---
 rtl/sprite_ram_arbiter_if.sv | 48 ++++
 rtl/sprite_ram_arbiter.sv | 138 +++++++++++++
 tb/tb_sprite_ram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_ram_arbiter_if
// Brief    : Pixel-read, loader-write and frameRAM signals of the sprite RAM
//            arbiter, bundled with arbiter (slave) and environment (master) views.
// Revision : 1.0 - initial release
// ============================================================================
interface sprite_ram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 4
);
    logic              pix_req;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_gnt;
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              blank;
    logic              ld_start;
    logic              ld_valid;
    logic              ld_last;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              load_done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  pix_req, pix_addr, blank,
        input  ld_start, ld_valid, ld_last, ld_addr, ld_data,
        input  ram_rdata,
        output pix_gnt, pix_valid, pix_data,
        output ld_ready, load_done,
        output ram_addr, ram_we, ram_wdata
    );

    modport master (
        output pix_req, pix_addr, blank,
        output ld_start, ld_valid, ld_last, ld_addr, ld_data,
        output ram_rdata,
        input  pix_gnt, pix_valid, pix_data,
        input  ld_ready, load_done,
        input  ram_addr, ram_we, ram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/sprite_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_ram_arbiter
// Brief    : Shares one single-port frameRAM between color-mapper reads and a
//            buffered sprite loader, writing during blanking or idle slots.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_ram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic          Clk,
    input  wire logic          Reset_n,
    sprite_ram_arbiter_if.slave bus
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_ENT_W = ADDR_W + DATA_W;

    localparam logic [c_PTR_W:0]   c_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(FIFO_DEPTH - 1);

    localparam logic [1:0] c_RUN   = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_done_nxt;

    logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic               r_gnt_d1;
    logic               r_pix_valid;
    logic [DATA_W-1:0]  r_pix_data;
    logic               r_load_done;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_wr_grant;
    logic [c_ENT_W-1:0] w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_head  = r_mem[r_rd_ptr];

    // No bypass: a full FIFO refuses the beat even when it pops this cycle.
    assign bus.ld_ready = (r_state == c_LOAD) && !w_full;
    assign w_push       = bus.ld_valid && bus.ld_ready;

    // Writes steal the port whenever the pixel side can spare it, or when the
    // buffer is full and the loader would otherwise stall indefinitely.
    assign w_wr_grant = !w_empty && (bus.blank || !bus.pix_req || w_full);

    assign bus.pix_gnt   = bus.pix_req && !w_wr_grant;
    assign bus.ram_we    = w_wr_grant;
    assign bus.ram_addr  = w_wr_grant ? w_head[c_ENT_W-1:DATA_W] : bus.pix_addr;
    assign bus.ram_wdata = w_empty ? '0 : w_head[DATA_W-1:0];

    assign bus.pix_valid = r_pix_valid;
    assign bus.pix_data  = r_pix_data;
    assign bus.load_done = r_load_done;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_RUN: begin
                if (bus.ld_start) begin
                    w_state_nxt = c_LOAD;
                end
            end
            c_LOAD: begin
                if (w_push && bus.ld_last) begin
                    w_state_nxt = c_DRAIN;
                end
            end
            c_DRAIN: begin
                // An empty FIFO also means no write is being issued this cycle.
                if (w_empty) begin
                    w_state_nxt = c_RUN;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_RUN;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.ld_addr, bus.ld_data};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= c_RUN;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_gnt_d1    <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_load_done <= w_done_nxt;

            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_wr_grant) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_wr_grant})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // RAM returns data the cycle after the address; capture it one edge later.
            r_gnt_d1    <= bus.pix_gnt;
            r_pix_valid <= r_gnt_d1;
            if (r_gnt_d1) begin
                r_pix_data <= bus.ram_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_ram_arbiter
// Brief    : Scoreboard bench for sprite_ram_arbiter with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_ram_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 4;

    logic Clk = 1'b0;
    logic Reset_n;

    always #5 Clk = ~Clk;

    sprite_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sprite_ram_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (4)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct {
        int         due;
        logic [3:0] data;
    } rd_t;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  data;
    } wr_t;

    rd_t rd_q[$];
    wr_t wr_q[$];

    int n_total  = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;

    // RAM content pattern; chosen so that address 0x1F40 holds 0x7.
    function automatic logic [3:0] pat(input logic [15:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ 4'hD;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] a, input logic [3:0] d, input logic last);
        logic ok;
        ok = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        bus.ld_last  = last;
        for (int n = 0; n < 50; n++) begin
            @(negedge Clk);
            if (bus.ld_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("beat_accept", ok, 1);
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    // Synchronous-read frameRAM model.
    always @(posedge Clk) begin
        bus.ram_rdata <= pat(bus.ram_addr);
    end

    // Scoreboard: reads complete two cycles after grant, writes follow beat order.
    always @(negedge Clk) begin
        cyc++;
        if (!Reset_n) begin
            rd_q.delete();
            wr_q.delete();
        end else begin
            chk("one_access", bus.ram_we & bus.pix_gnt, 0);

            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                chk("rd_valid", bus.pix_valid, 1);
                chk("rd_data", bus.pix_data, rd_q[0].data);
                void'(rd_q.pop_front());
            end else begin
                chk("rd_spurious", bus.pix_valid, 0);
            end
            if (bus.pix_gnt) begin
                rd_q.push_back('{due: cyc + 2, data: pat(bus.pix_addr)});
            end

            if (bus.ram_we) begin
                wr_cnt++;
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", bus.ram_we, 0);
                end else begin
                    chk("wr_addr", bus.ram_addr, wr_q[0].addr);
                    chk("wr_data", bus.ram_wdata, wr_q[0].data);
                    void'(wr_q.pop_front());
                end
            end
            if (bus.ld_valid && bus.ld_ready) begin
                wr_q.push_back('{addr: bus.ld_addr, data: bus.ld_data});
            end

            if (bus.load_done) begin
                done_cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w0;
        int d0;
        int idx;
        int e_rdy [10] = '{1, 1, 1, 1, 0, 1, 0, 1, 0, 0};
        int e_we  [10] = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0};
        int e_gnt [10] = '{1, 1, 1, 1, 0, 1, 0, 1, 0, 1};

        Reset_n      = 1'b0;
        bus.pix_req  = 1'b0;
        bus.pix_addr = '0;
        bus.blank    = 1'b0;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_pix_valid", bus.pix_valid, 0);
        chk("rst_pix_data",  bus.pix_data,  0);
        chk("rst_load_done", bus.load_done, 0);
        chk("rst_ld_ready",  bus.ld_ready,  0);
        chk("rst_ram_we",    bus.ram_we,    0);
        tick();
        Reset_n = 1'b1;
        tick();

        // Single read: grant same cycle, data two cycles later
        bus.pix_req  = 1'b1;
        bus.pix_addr = 16'h1F40;
        @(negedge Clk);
        chk("t1_gnt", bus.pix_gnt, 1);
        chk("t1_ram_addr", bus.ram_addr, 16'h1F40);
        tick();
        bus.pix_req = 1'b0;
        @(negedge Clk);
        chk("t1_valid_n1", bus.pix_valid, 0);
        @(negedge Clk);
        chk("t1_valid_n2", bus.pix_valid, 1);
        chk("t1_data", bus.pix_data, 4'h7);
        tick();

        // Random reads with the FIFO empty: every request is granted
        repeat (24) begin
            bus.pix_req  = 1'($urandom_range(0, 1));
            bus.pix_addr = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
            @(negedge Clk);
            chk("rd_gnt", bus.pix_gnt, bus.pix_req);
            tick();
        end
        bus.pix_req = 1'b0;
        repeat (3) tick();

        // Three-beat load during blanking
        bus.blank = 1'b1;
        d0 = done_cnt;
        w0 = wr_cnt;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_beat(16'(i), 4'(i + 1), (i == 2));
        end
        repeat (10) @(negedge Clk);
        chk("t2_writes", wr_cnt - w0, 3);
        chk("t2_done", done_cnt - d0, 1);
        tick();

        // Back-to-back beats against continuous pixel reads; ld_start in LOAD ignored
        bus.blank    = 1'b0;
        bus.pix_req  = 1'b1;
        bus.pix_addr = 16'h8123;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        d0  = done_cnt;
        w0  = wr_cnt;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            bus.ld_start = (c == 1 || c == 2);
            if (idx < 6) begin
                bus.ld_valid = 1'b1;
                bus.ld_addr  = 16'h0010 + 16'(idx);
                bus.ld_data  = 4'(idx) + 4'h9;
                bus.ld_last  = (idx == 5);
            end else begin
                bus.ld_valid = 1'b0;
                bus.ld_last  = 1'b0;
            end
            @(negedge Clk);
            chk("t3_ld_ready", bus.ld_ready, e_rdy[c]);
            chk("t3_ram_we",   bus.ram_we,   e_we[c]);
            chk("t3_pix_gnt",  bus.pix_gnt,  e_gnt[c]);
            if (bus.ld_valid && bus.ld_ready) begin
                idx++;
            end
            tick();
        end
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        chk("t3_beats", idx, 6);
        bus.pix_req = 1'b0;
        repeat (8) @(negedge Clk);
        chk("t3_writes", wr_cnt - w0, 6);
        chk("t3_done", done_cnt - d0, 1);
        tick();

        // Reset in DRAIN with two entries held back by pixel traffic
        bus.pix_req  = 1'b1;
        bus.pix_addr = 16'h8123;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        send_beat(16'h0020, 4'h1, 1'b0);
        send_beat(16'h0021, 4'h2, 1'b1);
        repeat (2) tick();
        chk("t5_pre_valid", bus.pix_valid, 1);
        d0 = done_cnt;
        w0 = wr_cnt;
        Reset_n = 1'b0;
        #1;
        chk("t5_pix_valid", bus.pix_valid, 0);
        chk("t5_pix_data",  bus.pix_data,  0);
        chk("t5_load_done", bus.load_done, 0);
        chk("t5_ld_ready",  bus.ld_ready,  0);
        chk("t5_ram_we",    bus.ram_we,    0);
        repeat (2) tick();
        Reset_n     = 1'b1;
        bus.pix_req = 1'b0;
        bus.blank   = 1'b1;
        repeat (10) @(negedge Clk);
        chk("t5_writes", wr_cnt - w0, 0);
        chk("t5_done", done_cnt - d0, 0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
